dmem_rmw_ctrl: RTL

//  Memory-side responder for the load/store path. Accepts one typed data-memory request at a time.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_lane_fmt.sv | 14 +
 rtl/dmem_rmw_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: access codes, FSM encoding and lane extract/merge helpers for dmem_rmw_ctrl
package dmem_pkg;
  localparam logic [3:0] ACC_LW  = 4'b0001;
  localparam logic [3:0] ACC_LH  = 4'b0010;
  localparam logic [3:0] ACC_LB  = 4'b0011;
  localparam logic [3:0] ACC_LHU = 4'b0100;
  localparam logic [3:0] ACC_LBU = 4'b0101;
  localparam logic [3:0] ACC_SW  = 4'b1001;
  localparam logic [3:0] ACC_SH  = 4'b1010;
  localparam logic [3:0] ACC_SB  = 4'b1011;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off, input logic [3:0] code);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    return code == ACC_LB  ? {{24{s[7]}}, s[7:0]} :
           code == ACC_LBU ? {24'b0, s[7:0]} :
           code == ACC_LH  ? {{16{s[15]}}, s[15:0]} :
           code == ACC_LHU ? {16'b0, s[15:0]} :
           code == ACC_LW  ? word : 32'b0;
  endfunction
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] data, input logic [1:0] off, input logic [3:0] code);
    logic [31:0] m;
    m = code == ACC_SB ? 32'h0000_00ff << {off, 3'b000} :
        code == ACC_SH ? 32'h0000_ffff << {off, 3'b000} : 32'hffff_ffff;
    return (old & ~m) | ((data << {off, 3'b000}) & m);
  endfunction
  function automatic logic [3:0] lane_be(input logic [1:0] off, input logic [3:0] code);
    return code == ACC_SB ? 4'b0001 << off : code == ACC_SH ? 4'b0011 << off : 4'b1111;
  endfunction
  function automatic logic [31:0] lane_rep(input logic [31:0] data, input logic [3:0] code);
    return code == ACC_SB ? {4{data[7:0]}} : code == ACC_SH ? {2{data[15:0]}} : data;
  endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational load-lane extraction and store-lane merge
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic [3:0]  code,
  output logic [31:0] ext,
  output logic [31:0] merged
);
  assign ext    = lane_extract(word, off, code);
  assign merged = lane_merge(word, data, off, code);
endmodule

// File: rtl/dmem_rmw_ctrl.sv
// dmem_rmw_ctrl: single-request data-memory responder with RMW sub-word stores; DMEM_BYTE_WE_EN adds mem_be and skips RMW
module dmem_rmw_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_access,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_wdata,
  output logic              mem_we
`ifdef DMEM_BYTE_WE_EN
  ,
  output logic [3:0]        mem_be
`endif
);
`ifdef DMEM_BYTE_WE_EN
  localparam bit BYTE_WE = 1'b1;
`else
  localparam bit BYTE_WE = 1'b0;
`endif
  state_t state, state_n;
  logic [ADDR_W+1:0] addr_q;
  logic [3:0] acc_q;
  logic [31:0] wdata_q, data_q, ext, merged;
  logic err_q, acc_err, legal, accept;
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign accept = req_valid && state == S_IDLE;
  always_comb begin
    legal = req_access inside {ACC_LW, ACC_LH, ACC_LB, ACC_LHU, ACC_LBU, ACC_SW, ACC_SH, ACC_SB};
    acc_err = !legal ||
              ((req_access == ACC_LW || req_access == ACC_SW) && req_addr[1:0] != 2'b00) ||
              ((req_access == ACC_LH || req_access == ACC_LHU || req_access == ACC_SH) && req_addr[0]);
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = !accept ? S_IDLE : acc_err ? S_RESP :
                        (req_access == ACC_SW || (BYTE_WE && req_access[3])) ? S_WR : S_RD;
      S_RD:   state_n = S_CAP;
      S_CAP:  state_n = acc_q[3] ? S_WR : S_RESP;
      S_WR:   state_n = S_RESP;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= req_addr[ADDR_W+1:0];
        acc_q   <= req_access;
        wdata_q <= req_wdata;
        err_q   <= acc_err;
      end
      if (state == S_CAP) data_q <= acc_q[3] ? merged : mem_rdata;
    end
  end
  // CAP merges against the fresh RAM word; RESP extracts from the captured one
  dmem_lane_fmt u_fmt (
    .word   (state == S_CAP ? mem_rdata : data_q),
    .data   (wdata_q),
    .off    (addr_q[1:0]),
    .code   (acc_q),
    .ext    (ext),
    .merged (merged)
  );
  assign req_ready  = state == S_IDLE;
  assign resp_valid = state == S_RESP;
  assign resp_err   = state == S_RESP && err_q;
  assign resp_rdata = (state == S_RESP && !err_q && !acc_q[3]) ? ext : 32'b0;
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_we     = state == S_WR;
`ifdef DMEM_BYTE_WE_EN
  assign mem_wdata  = mem_we ? lane_rep(wdata_q, acc_q) : 32'b0;
  assign mem_be     = mem_we ? lane_be(addr_q[1:0], acc_q) : 4'b0;
`else
  assign mem_wdata  = mem_we ? (acc_q == ACC_SW ? wdata_q : data_q) : 32'b0;
`endif
endmodule
